// File: rtl/input_debounce_sync.sv
// Pin conditioner: N-stage synchroniser + counter-qualified debounce FSM with rise/fall pulses and event count.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted checks on glitch_cnt.
module input_debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       din,
  input  logic       clr_cnt,
  output logic       dout,
  output logic       rise,
  output logic       fall,
  output logic [7:0] event_cnt,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;
  logic [7:0]             evt_q, evt_d;
  logic                   abort;

  // Synchroniser is free-running; ena only gates the qualification logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE_LOW: if (s) begin
          state_d = CHK_HIGH;
          cnt_d   = '0;
        end
        CHK_HIGH: if (!s) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        IDLE_HIGH: if (!s) begin
          state_d = CHK_LOW;
          cnt_d   = '0;
        end
        CHK_LOW: if (s) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Counter bumps on the same edge that raises rise; clear wins over increment.
  always_comb begin
    evt_d = evt_q;
    if (clr_cnt)     evt_d = 8'h00;
    else if (rise_d) evt_d = evt_q + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      evt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      evt_q   <= evt_d;
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] glitch_q, glitch_d;

  always_comb begin
    glitch_d = glitch_q;
    if (clr_cnt)                        glitch_d = 8'h00;
    else if (abort && glitch_q != 8'hFF) glitch_d = glitch_q + 8'h01;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) glitch_q <= 8'h00;
    else     glitch_q <= glitch_d;
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign glitch_cnt   = 8'h00;
`endif

  assign dout      = dout_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign event_cnt = evt_q;

endmodule
